lmsm_mem_sequencer: RTL and testbench

- Multi-cycle controller that sequences the data memory for IITB-RISC Load-Multiple (LM) and Store-Multiple (SM) instructions.
- Sits between the MEM stage and the data memory port (MemRead/MemWrite/Addr/Din/Dout).
- Walks an 8-bit register mask and issues one memory access per cycle at consecutive addresses.
- Stalls the pipeline until all accesses finish.

---
 rtl/lmsm_pkg.sv | 17 +
 rtl/lmsm_prio_enc.sv | 24 ++
 rtl/lmsm_mem_sequencer.sv | 150 +++++++++++++++
 tb/tb_lmsm_mem_sequencer.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lmsm_pkg.sv
// lmsm_pkg: shared state type and default sizes for the LM/SM memory sequencer.
package lmsm_pkg;

  // Register-file size; the LM/SM register mask has one bit per register.
  localparam int unsigned NREG_DEFAULT       = 8;
  // Width of a register index (R0..R7).
  localparam int unsigned REG_IDX_W          = 3;
  // Data memory size in words, only consulted by the optional bounds check.
  localparam int unsigned DMEM_DEPTH_DEFAULT = 4096;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } lmsm_state_e;

endpackage

// File: rtl/lmsm_prio_enc.sv
// lmsm_prio_enc: combinational lowest-set-bit encoder for the LM/SM register mask.
module lmsm_prio_enc
  import lmsm_pkg::*;
#(
  parameter int unsigned NREG = NREG_DEFAULT
) (
  input  logic [NREG-1:0]      mask,
  output logic [REG_IDX_W-1:0] idx,
  output logic                 valid
);

  // Scan from the top down so the last hit, the lowest set bit, wins (R0 first).
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = int'(NREG) - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx   = REG_IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lmsm_mem_sequencer.sv
// lmsm_mem_sequencer: multi-cycle data-memory sequencer for IITB-RISC LM/SM.
// Walks the latched register mask from R0 upwards and issues one memory access
// per cycle at consecutive addresses, stalling the pipeline until finished.
// Optional feature macro: LMSM_BOUNDS_CHECK_EN (abort with an err pulse when the
// current address is at or beyond DMEM_DEPTH).
module lmsm_mem_sequencer
  import lmsm_pkg::*;
#(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned NREG       = NREG_DEFAULT,
  parameter int unsigned DMEM_DEPTH = DMEM_DEPTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 is_store,
  input  logic [NREG-1:0]      reg_mask,
  input  logic [ADDR_W-1:0]    base_addr,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]    mem_din,
  input  logic [DATA_W-1:0]    mem_dout,
  output logic [REG_IDX_W-1:0] rf_rd_idx,
  input  logic [DATA_W-1:0]    rf_rdata,
  output logic                 rf_we,
  output logic [REG_IDX_W-1:0] rf_wr_idx,
  output logic [DATA_W-1:0]    rf_wdata,
  output logic                 stall,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  lmsm_state_e           state_q, state_d;
  logic [NREG-1:0]       rem_q, rem_d;
  logic [NREG-1:0]       rem_after;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  dir_q, dir_d;
  logic [REG_IDX_W-1:0]  idx;
  logic                  idx_valid;
  logic                  oob;

  lmsm_prio_enc #(
    .NREG (NREG)
  ) u_prio_enc (
    .mask  (rem_q),
    .idx   (idx),
    .valid (idx_valid)
  );

  // Remaining mask once the register picked this cycle has been transferred.
  assign rem_after = rem_q & ~(NREG'(1) << idx);

`ifdef LMSM_BOUNDS_CHECK_EN
  // Current access falls outside the physical data memory.
  assign oob = (32'(addr_q) >= DMEM_DEPTH);
`else
  // Unchecked build: addresses simply wrap at 2^ADDR_W.
  assign oob = 1'b0;
`endif

  // Data paths are straight wires; only the strobes qualify them.
  assign mem_din  = rf_rdata;
  assign rf_wdata = mem_dout;

  assign busy  = (state_q != StIdle);
  // Combinational so the LM/SM is frozen in its issue cycle.
  assign stall = busy | (start & (state_q == StIdle));

  // State, remaining mask, address pointer and direction registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      rem_q   <= '0;
      addr_q  <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      addr_q  <= addr_d;
      dir_q   <= dir_d;
    end
  end

  // Next-state logic and per-cycle memory / register-file strobes.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    addr_d    = addr_q;
    dir_d     = dir_q;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    rf_rd_idx = '0;
    rf_we     = 1'b0;
    rf_wr_idx = '0;
    done      = 1'b0;
    err       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          rem_d   = reg_mask;
          addr_d  = base_addr;
          dir_d   = is_store;
          state_d = (reg_mask != '0) ? StRun : StDone;
        end
      end

      StRun: begin
        if (oob) begin
          // Abort: no strobes this cycle, drop whatever is left.
          err     = 1'b1;
          rem_d   = '0;
          state_d = StDone;
        end else if (idx_valid) begin
          mem_addr = addr_q;
          if (dir_q) begin
            mem_write = 1'b1;
            rf_rd_idx = idx;
          end else begin
            // Memory read is combinational, so the register is written this cycle.
            mem_read  = 1'b1;
            rf_we     = 1'b1;
            rf_wr_idx = idx;
          end
          rem_d  = rem_after;
          addr_d = addr_q + 1'b1;
          if (rem_after == '0) begin
            state_d = StDone;
          end
        end else begin
          state_d = StDone;
        end
      end

      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

endmodule

// File: tb/tb_lmsm_mem_sequencer.sv
// tb_lmsm_mem_sequencer: random + directed bench for lmsm_mem_sequencer.
// Keeps a transaction-level model (a precomputed list of accesses per operation)
// and compares every DUT output against it on each falling clock edge.
module tb_lmsm_mem_sequencer;

  localparam int unsigned DEPTH = 4096;
`ifdef LMSM_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start, is_store;
  logic [7:0]  reg_mask;
  logic [15:0] base_addr;
  logic        mem_read, mem_write, rf_we, stall, busy, done, err;
  logic [15:0] mem_addr, mem_din, mem_dout, rf_rdata, rf_wdata;
  logic [2:0]  rf_rd_idx, rf_wr_idx;

  // Preload requests, applied at a rising edge to both environment and model.
  logic        pl_mem_en, pl_rf_en;
  logic [15:0] pl_addr, pl_val;
  logic [2:0]  pl_idx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lmsm_mem_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_store  (is_store),
    .reg_mask  (reg_mask),
    .base_addr (base_addr),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout),
    .rf_rd_idx (rf_rd_idx),
    .rf_rdata  (rf_rdata),
    .rf_we     (rf_we),
    .rf_wr_idx (rf_wr_idx),
    .rf_wdata  (rf_wdata),
    .stall     (stall),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  // Environment: data memory and register file driven by the DUT strobes.
  bit [15:0] env_mem [65536];
  bit [15:0] env_rf  [8];

  assign mem_dout = env_mem[mem_addr];
  assign rf_rdata = env_rf[rf_rd_idx];

  always @(posedge clk) begin
    if (rst_n) begin
      if (mem_write) env_mem[mem_addr] <= mem_din;
      if (rf_we)     env_rf[rf_wr_idx] <= rf_wdata;
    end
    if (pl_mem_en) env_mem[pl_addr] <= pl_val;
    if (pl_rf_en)  env_rf[pl_idx]   <= pl_val;
  end

  // Reference model: an operation is a list of accesses built from the mask.
  typedef struct {
    bit        st;
    bit        oob;
    int        idx;
    bit [15:0] addr;
  } acc_t;

  acc_t      acc_q[$];
  int        m_state;   // 0 idle, 1 transferring, 2 completion cycle
  bit [15:0] ref_mem [65536];
  bit [15:0] ref_rf  [8];

  function automatic void build_ops(input bit st, input logic [7:0] m, input logic [15:0] b);
    bit [15:0] a = b;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) begin
        acc_t e;
        e.st   = st;
        e.idx  = i;
        e.addr = a;
        e.oob  = BOUNDS && (int'(a) >= int'(DEPTH));
        acc_q.push_back(e);
        if (e.oob) break;
        a = a + 16'd1;
      end
    end
  endfunction

  initial begin
    acc_t h;
    m_state = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_state = 0;
        acc_q.delete();
      end else begin
        if (pl_mem_en) ref_mem[pl_addr] = pl_val;
        if (pl_rf_en)  ref_rf[pl_idx]   = pl_val;
        if (m_state == 0) begin
          if (start) begin
            build_ops(is_store, reg_mask, base_addr);
            m_state = (acc_q.size() != 0) ? 1 : 2;
          end
        end else if (m_state == 1) begin
          h = acc_q.pop_front();
          if (h.oob) begin
            acc_q.delete();
            m_state = 2;
          end else begin
            if (h.st) ref_mem[h.addr] = ref_rf[h.idx];
            else      ref_rf[h.idx]   = ref_mem[h.addr];
            if (acc_q.size() == 0) m_state = 2;
          end
        end else begin
          m_state = 0;
        end
      end
    end
  end

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Per-cycle comparison of every DUT output against the model.
  task automatic compare();
    logic er = 0, ew = 0, ewe = 0, ed = 0, eerr = 0, eb, es;
    logic [15:0] ea = '0, edin = '0, ewd = '0;
    logic [2:0]  eri = '0, ewi = '0;
    acc_t h;
    eb = (m_state != 0);
    es = eb || (start && (m_state == 0));
    if (m_state == 1) begin
      h = acc_q[0];
      if (h.oob) begin
        eerr = 1;
      end else begin
        ea = h.addr;
        if (h.st) begin
          ew   = 1;
          eri  = 3'(h.idx);
          edin = ref_rf[h.idx];
        end else begin
          er  = 1;
          ewe = 1;
          ewi = 3'(h.idx);
          ewd = ref_mem[h.addr];
        end
      end
    end
    ed = (m_state == 2);
    check("mem_read",  32'(mem_read),  32'(er));
    check("mem_write", 32'(mem_write), 32'(ew));
    check("rf_we",     32'(rf_we),     32'(ewe));
    check("busy",      32'(busy),      32'(eb));
    check("stall",     32'(stall),     32'(es));
    check("done",      32'(done),      32'(ed));
    check("err",       32'(err),       32'(eerr));
    if (er || ew) check("mem_addr", 32'(mem_addr), 32'(ea));
    if (ew) begin
      check("rf_rd_idx", 32'(rf_rd_idx), 32'(eri));
      check("mem_din",   32'(mem_din),   32'(edin));
    end
    if (ewe) begin
      check("rf_wr_idx", 32'(rf_wr_idx), 32'(ewi));
      check("rf_wdata",  32'(rf_wdata),  32'(ewd));
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      compare();
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic nedge();
    @(negedge clk);
    #1;
  endtask

  task automatic preload_rf(input logic [2:0] i, input logic [15:0] v);
    pl_rf_en = 1'b1;
    pl_idx   = i;
    pl_val   = v;
    step();
    pl_rf_en = 1'b0;
  endtask

  task automatic preload_mem(input logic [15:0] a, input logic [15:0] v);
    pl_mem_en = 1'b1;
    pl_addr   = a;
    pl_val    = v;
    step();
    pl_mem_en = 1'b0;
  endtask

  task automatic issue(input logic st, input logic [7:0] m, input logic [15:0] b);
    start     = 1'b1;
    is_store  = st;
    reg_mask  = m;
    base_addr = b;
  endtask

  // Waits (bounded) for the done pulse; returns sampled just after that falling edge.
  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      nedge();
      if (done) seen = 1'b1;
    end
    check(name, 32'(seen), 32'd1);
  endtask

  initial begin
    int nw, nerr;
    bit seen;
    logic       st;
    logic [7:0] m;
    logic [15:0] b;

    start = 0; is_store = 0; reg_mask = '0; base_addr = '0;
    pl_mem_en = 0; pl_rf_en = 0; pl_addr = '0; pl_val = '0; pl_idx = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("reset_busy",  32'(busy),  32'd0);
    check("reset_done",  32'(done),  32'd0);
    check("reset_stall", 32'(stall), 32'd0);
    check("reset_strobes", 32'({mem_read, mem_write, rf_we, err}), 32'd0);
    rst_n = 1'b1;
    step();

    // SM mask 0x05 from 0x0010.
    preload_rf(3'd0, 16'hAAAA);
    preload_rf(3'd2, 16'h5555);
    issue(1'b1, 8'h05, 16'h0010);
    nedge();
    check("sm05_c0_stall", 32'(stall), 32'd1);
    check("sm05_c0_busy",  32'(busy),  32'd0);
    step(); start = 1'b0;
    nedge();
    check("sm05_c1_we",   32'(mem_write), 32'd1);
    check("sm05_c1_addr", 32'(mem_addr),  32'h0010);
    check("sm05_c1_din",  32'(mem_din),   32'hAAAA);
    step(); nedge();
    check("sm05_c2_addr", 32'(mem_addr),  32'h0011);
    check("sm05_c2_din",  32'(mem_din),   32'h5555);
    check("sm05_c2_stall", 32'(stall),    32'd1);
    step(); nedge();
    check("sm05_c3_done", 32'(done),  32'd1);
    check("sm05_c3_stall", 32'(stall), 32'd1);
    step(); nedge();
    check("sm05_c4_busy", 32'(busy), 32'd0);
    check("sm05_mem10",     32'(env_mem[16'h0010]), 32'hAAAA);
    check("sm05_mem11",     32'(env_mem[16'h0011]), 32'h5555);
    check("sm05_model_m11", 32'(ref_mem[16'h0011]), 32'h5555);
    step();

    // LM mask 0x80 from 0x0100.
    preload_mem(16'h0100, 16'h1234);
    issue(1'b0, 8'h80, 16'h0100);
    step(); start = 1'b0;
    nedge();
    check("lm80_rf_we",  32'(rf_we),     32'd1);
    check("lm80_rd",     32'(mem_read),  32'd1);
    check("lm80_idx",    32'(rf_wr_idx), 32'd7);
    check("lm80_wdata",  32'(rf_wdata),  32'h1234);
    step(); nedge();
    check("lm80_done", 32'(done), 32'd1);
    step();
    check("lm80_r7",       32'(env_rf[7]), 32'h1234);
    check("lm80_model_r7", 32'(ref_rf[7]), 32'h1234);

    // LM with an empty mask: straight to the completion cycle.
    issue(1'b0, 8'h00, 16'h0200);
    step(); start = 1'b0;
    nedge();
    check("lm00_done",    32'(done), 32'd1);
    check("lm00_busy",    32'(busy), 32'd1);
    check("lm00_strobes", 32'({mem_read, mem_write, rf_we}), 32'd0);
    step(); nedge();
    check("lm00_idle", 32'(busy), 32'd0);
    step();

    // SM all registers from 0xFFFE: wraps, or aborts under the bounds check.
    for (int i = 0; i < 8; i++) preload_rf(3'(i), 16'h1000 + 16'(i));
    issue(1'b1, 8'hFF, 16'hFFFE);
    step(); start = 1'b0;
    nw = 0; nerr = 0; seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      nedge();
      if (mem_write) nw++;
      if (err) nerr++;
      if (done) seen = 1'b1;
      else step();
    end
    check("smff_done_seen", 32'(seen), 32'd1);
    step();
    if (BOUNDS) begin
      check("smff_writes", 32'(nw),   32'd0);
      check("smff_err",    32'(nerr), 32'd1);
    end else begin
      check("smff_writes",   32'(nw),   32'd8);
      check("smff_err",      32'(nerr), 32'd0);
      check("smff_memfffe",  32'(env_mem[16'hFFFE]), 32'h1000);
      check("smff_mem0005",  32'(env_mem[16'h0005]), 32'h1007);
      check("smff_model_05", 32'(ref_mem[16'h0005]), 32'h1007);
    end

    // Reset during an 8-register LM, after its second access.
    issue(1'b0, 8'hFF, 16'h0200);
    step(); start = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("rst_strobes", 32'({mem_read, mem_write, rf_we}), 32'd0);
    check("rst_busy",    32'(busy), 32'd0);
    step(); step();
    rst_n = 1'b1;
    nedge();
    check("rst_after_busy",  32'(busy),  32'd0);
    check("rst_after_stall", 32'(stall), 32'd0);
    step();

    // start held across completion: second operation follows the done cycle.
    issue(1'b1, 8'h03, 16'h0400);
    step(); step(); step();
    nedge();
    check("hold_done", 32'(done), 32'd1);
    step(); nedge();
    check("hold_idle_busy",  32'(busy),  32'd0);
    check("hold_idle_stall", 32'(stall), 32'd1);
    step(); nedge();
    check("hold_second_we",   32'(mem_write), 32'd1);
    check("hold_second_addr", 32'(mem_addr),  32'h0400);
    step(); start = 1'b0;
    wait_done("hold_second_done");
    step();

    // A start pulse while busy is ignored.
    issue(1'b0, 8'hFF, 16'h0300);
    step(); start = 1'b0;
    step();
    issue(1'b1, 8'h01, 16'h0500);
    step(); start = 1'b0;
    wait_done("busy_pulse_done");
    step(); nedge();
    check("busy_pulse_idle", 32'(busy), 32'd0);
    step();

    // Randomized operations.
    for (int n = 0; n < 150; n++) begin
      st = 1'($urandom_range(0, 1));
      m  = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
      case ($urandom_range(0, 3))
        0:       b = 16'hFFF8 + 16'($urandom_range(0, 7));
        1:       b = 16'($urandom_range(0, 4095));
        2:       b = 16'(4088 + $urandom_range(0, 15));
        default: b = 16'($urandom);
      endcase
      if (!st) begin
        for (int k = 0; k < 8; k++) preload_mem(b + 16'(k), 16'($urandom));
      end else if (n % 4 == 0) begin
        for (int k = 0; k < 8; k++) preload_rf(3'(k), 16'($urandom));
      end
      issue(st, m, b);
      step(); start = 1'b0;
      if ($countones(m) >= 3 && $urandom_range(0, 2) == 0) begin
        step();
        issue(1'($urandom_range(0, 1)), 8'($urandom), 16'($urandom));
        step(); start = 1'b0;
      end
      wait_done($sformatf("rand_done_%0d", n));
      step();
    end

    step(); step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
